// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM.
// Every output is registered alongside the state.
module sram_arbiter #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [ADDR-1:0]  addr0,
  input  logic [ADDR-1:0]  addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             sram_cs,
  output logic             sram_we,
  output logic [ADDR-1:0]  sram_addr,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata
);

  // state  | meaning
  // IDLE   | sample requests, pick a winner
  // ACCESS | SRAM strobed for the winner, gnt pulsed
  // RESP   | read data presented with rvalid
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             rv0_q, rv0_d, rv1_q, rv1_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d, swe_q, swe_d;
  logic [ADDR-1:0]  saddr_q, saddr_d;
  logic [WIDTH-1:0] swdata_q, swdata_d;
  logic             win;

  always_comb begin
    // On a tie the requester not served last wins; a lone requester always wins.
    win      = (req0 && req1) ? ~ptr_q : req1;
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    we_d     = we_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rdata_d  = rdata_q;
    cs_d     = 1'b0;
    swe_d    = 1'b0;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d     = win;
          ptr_d    = win;
          we_d     = win ? we1 : we0;
          saddr_d  = win ? addr1 : addr0;
          swdata_d = win ? wdata1 : wdata0;
          cs_d     = 1'b1;
          swe_d    = win ? we1 : we0;
          gnt0_d   = ~win;
          gnt1_d   = win;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          // Read data is valid at the edge closing the strobe cycle.
          rdata_d = sram_rdata;
          rv0_d   = ~id_q;
          rv1_d   = id_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b0;
      swe_q    <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      we_q     <= we_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      swe_q    <= swe_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rvalid0    = rv0_q;
  assign rvalid1    = rv1_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign sram_cs    = cs_q;
  assign sram_we    = swe_q;
  assign sram_addr  = saddr_q;
  assign sram_wdata = swdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: hand tables, corner sequences and random traffic
// checked against a memory/last-served model.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, sram_cs, sram_we;
  logic [7:0] rdata, sram_wdata, sram_rdata;
  logic [3:0] sram_addr;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  bit         last = 1'b1;
  int         vec_cnt = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM model: synchronous write, read data available for the closing edge.
  always @(posedge clk) if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_addr];

  always @(negedge clk) begin
    if (!rst && ((gnt0 && gnt1) || (rvalid0 && rvalid1) ||
                 ((gnt0 || gnt1) && (rvalid0 || rvalid1)))) begin
      miscompares++;
      $display("FAIL excl: gnt=%b%b rvalid=%b%b, required at most one pulse",
               gnt1, gnt0, rvalid1, rvalid0);
    end
  end

  typedef struct {
    bit r0, r1, w0, w1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    bit exp_win;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Starts at #1 after an edge with the DUT idle; ends the same way.
  task automatic run_txn(input vec_t v);
    bit w;
    logic we_w;
    logic [3:0] a;
    logic [7:0] d;
    w = v.exp_win;
    we_w = w ? v.w1 : v.w0;
    a = w ? v.a1 : v.a0;
    d = w ? v.d1 : v.d0;
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(posedge clk); #1;
    check("gnt0", gnt0, !w);
    check("gnt1", gnt1, w);
    check("acc_cs", sram_cs, 1);
    check("acc_we", sram_we, we_w);
    check("acc_addr", sram_addr, a);
    check("acc_wdata", sram_wdata, d);
    check("acc_busy", busy, 1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    if (!we_w) begin
      check("rvalid0", rvalid0, !w);
      check("rvalid1", rvalid1, w);
      check("rdata", rdata, v.exp_rdata);
      check("resp_cs", sram_cs, 0);
      check("resp_busy", busy, 1);
      @(posedge clk); #1;
    end
    check("idle_busy", busy, 0);
    check("idle_cs", sram_cs, 0);
    check("idle_rvalid", {rvalid1, rvalid0}, 0);
    if (we_w) ref_mem[a] = d;
    last = w;
  endtask

  initial begin
    int q[$];
    int cs_cnt, g1_cnt;
    vec_t v;
    logic [1:0] r;

    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    //          r0 r1 w0 w1 a0  a1  d0     d1     win rdata
    tbl[0] = '{1, 0, 1, 0, 3,  0,  8'hA5, 8'h00, 0, 8'h00};
    tbl[1] = '{1, 0, 0, 0, 3,  0,  8'h00, 8'h00, 0, 8'hA5};
    tbl[2] = '{0, 1, 0, 1, 0,  15, 8'h00, 8'h3C, 1, 8'h00};
    tbl[3] = '{1, 0, 0, 0, 15, 0,  8'h00, 8'h00, 0, 8'h3C};
    tbl[4] = '{1, 1, 0, 0, 3,  15, 8'h00, 8'h00, 1, 8'h3C};
    tbl[5] = '{1, 1, 1, 0, 7,  3,  8'h5A, 8'h00, 0, 8'h00};
    tbl[6] = '{1, 1, 0, 1, 7,  0,  8'h00, 8'h11, 1, 8'h00};
    tbl[7] = '{0, 1, 0, 0, 0,  7,  8'h00, 8'h00, 1, 8'h5A};
    tbl[8] = '{1, 1, 0, 0, 0,  7,  8'h00, 8'h00, 0, 8'h11};

    // Reset values hold without a clock edge mattering.
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_outs", {gnt0, gnt1, rvalid0, rvalid1, busy, sram_cs, sram_we}, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    last = 1'b1;

    // Tie after reset, both held: 0,1,0,1.
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 1; addr1 = 2;
    for (int c = 0; c < 20 && q.size() < 4; c++) begin
      @(posedge clk); #1;
      if (gnt0) q.push_back(0);
      if (gnt1) q.push_back(1);
    end
    req0 = 0; req1 = 0;
    check("tie_grants", q.size(), 4);
    for (int i = 0; i < q.size(); i++) check("tie_order", q[i], i % 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("tie_idle", busy, 0);
    last = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Address sweep.
    for (int i = 0; i < 16; i++) begin
      v = '{1, 0, 1, 0, i[3:0], 0, i[7:0] ^ 8'hFF, 8'h00, 0, 8'h00};
      run_txn(v);
    end
    for (int i = 0; i < 16; i++) begin
      v = '{1, 0, 0, 0, i[3:0], 0, 8'h00, 8'h00, 0, i[7:0] ^ 8'hFF};
      run_txn(v);
    end

    // Withdrawn req1 pulse during a requester-0 read.
    cs_cnt = 0; g1_cnt = 0;
    req0 = 1; we0 = 0; addr0 = 5;
    @(posedge clk); #1;
    check("wd_gnt0", gnt0, 1);
    cs_cnt += sram_cs;
    req0 = 0; req1 = 1; we1 = 1; addr1 = 9; wdata1 = 8'hEE;
    @(posedge clk); #1;
    check("wd_rvalid0", rvalid0, 1);
    check("wd_rdata", rdata, ref_mem[5]);
    req1 = 0;
    for (int c = 0; c < 4; c++) begin
      cs_cnt += sram_cs;
      g1_cnt += gnt1;
      @(posedge clk); #1;
    end
    check("wd_cs_count", cs_cnt, 1);
    check("wd_gnt1_count", g1_cnt, 0);
    last = 1'b0;

    // Reset during the RESP cycle of a read.
    req0 = 1; we0 = 0; addr0 = 3;
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_outs", {gnt0, gnt1, rvalid0, rvalid1, busy, sram_cs, sram_we}, 0);
    check("mid_addr_data", {sram_addr, sram_wdata, rdata}, 0);
    @(posedge clk); #1 rst = 1'b0;
    last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("mid_after", {rvalid0, gnt0, busy}, 0);
    end

    // Random traffic against the memory / last-served model.
    for (int n = 0; n < 60; n++) begin
      r = 2'($urandom_range(1, 3));
      v.r0 = r[0]; v.r1 = r[1];
      v.w0 = 1'($urandom_range(0, 1)); v.w1 = 1'($urandom_range(0, 1));
      v.a0 = 4'($urandom_range(0, 15)); v.a1 = 4'($urandom_range(0, 15));
      v.d0 = 8'($urandom_range(0, 255)); v.d1 = 8'($urandom_range(0, 255));
      v.exp_win = (v.r0 && v.r1) ? !last : v.r1;
      v.exp_rdata = ref_mem[v.exp_win ? v.a1 : v.a0];
      run_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR, default 4, SRAM address width in bits.
REQ-002 Parameter WIDTH, default 8, SRAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1; held high until the matching gnt.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; stable while req is high.
REQ-007 addr0 / addr1  input  ADDR  access address; stable while req is high.
REQ-008 wdata0 / wdata1  input  WIDTH  write data; stable while req is high.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse while the SRAM access for that requester is driven.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse when rdata holds read data for that requester.
REQ-011 rdata  output  WIDTH  read data, shared by both requesters, qualified by rvalid0/rvalid1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 sram_cs, sram_we  output  1  SRAM chip select and write enable.
REQ-014 sram_addr  output  ADDR; sram_wdata  output  WIDTH  SRAM address and write data.
REQ-015 sram_rdata  input  WIDTH  SRAM data_out; valid on the clock edge after a cycle with sram_cs=1 and sram_we=0.

Function
REQ-016 FSM states are IDLE, ACCESS and RESP; all outputs are registered.
REQ-017 IDLE: with no req high, stay in IDLE with sram_cs=0.
- With any req high, select a winner, latch its id, we, addr and wdata, and go to ACCESS.
REQ-018 Arbitration is round-robin with a 1-bit last-served pointer.
- If both req are high, the requester not last served wins.
- A single requester wins regardless of the pointer.
- The pointer updates to the winner's id on entry to ACCESS.
REQ-019 ACCESS (one cycle): drive sram_cs=1, sram_we=latched we, and sram_addr/sram_wdata from the latched values.
- Assert gnt of the winner.
- Next state is IDLE for a write and RESP for a read.
REQ-020 RESP (one cycle): sram_cs=0.
- Capture sram_rdata into rdata, pulse rvalid of the winner, then go to IDLE.
REQ-021 Latency: a write occupies 2 cycles, IDLE to ACCESS.
- A read occupies 3 cycles; rvalid comes exactly one cycle after gnt.
REQ-022 Requests are sampled only in IDLE.
- A req dropped before it is sampled causes no access.
- A requester must drop req in the cycle after its gnt, or it is treated as a new request.
REQ-023 rdata holds its last captured value until the next RESP.
- sram_addr and sram_wdata hold their last values while sram_cs=0.
REQ-024 At most one gnt and at most one rvalid are high in any cycle; gnt and rvalid are never high in the same cycle.
REQ-025 No request is starved: with both req held continuously, grants alternate 0,1,0,1...

Reset
REQ-026 While rst is high, the block drives the following regardless of clk:
- state=IDLE, pointer=1, so requester 0 wins the first tie.
- gnt0=gnt1=rvalid0=rvalid1=0, sram_cs=sram_we=0, busy=0.
- sram_addr=0, sram_wdata=0, rdata=0.
REQ-027 Reset asserted during ACCESS or RESP aborts the transaction.
- No gnt or rvalid is issued for it after reset releases.
- A write already clocked into the SRAM is not undone.

Verification
REQ-028 Write then read: req0, we0=1, addr0=3, wdata0=8'hA5.
- Required: gnt0 pulse with sram_cs=1, sram_we=1, sram_addr=3, sram_wdata=8'hA5.
- Then a read of addr 3 by req0: gnt0, and one cycle later rvalid0=1 with rdata=8'hA5.
REQ-029 Tie after reset: req0 and req1 both reads, asserted in the same cycle.
- Required: requester 0 granted first, then requester 1.
- Over 4 held accesses the grant order is 0,1,0,1.
REQ-030 Independent data: requester 1 writes 8'h3C to addr 15, then requester 0 reads addr 15.
- Required: rvalid0 with rdata=8'h3C; rvalid1 stays 0.
REQ-031 Reset mid-read: assert rst in the RESP cycle of a read.
- Required: rvalid0 stays 0, all outputs are 0 immediately, busy=0 after release.
REQ-032 Withdrawn request: pulse req1 for a cycle while a requester-0 read is in progress.
- Required: no gnt1 and no SRAM access for requester 1.
REQ-033 Address sweep: requester 0 writes addr i with value i^8'hFF for i=0..15, then reads all 16.
- Required: every rdata matches; each read takes 3 cycles and each write 2 cycles.
